// File: rtl/combo_pkg.sv
// Shared types and constants for the combination checker.
// The LOCKOUT state only exists when COMBO_LOCKOUT_EN is defined.
package combo_pkg;

  localparam int CODE_LEN = 4;                    // digits per combination
  localparam int DIGIT_W  = 4;                    // bits per digit
  localparam int ENT_W    = CODE_LEN * DIGIT_W;   // width of the entry register
  localparam int CNT_W    = 3;                    // digit counter width, holds 0..4

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_CHECK   = 2'd1,
`ifdef COMBO_LOCKOUT_EN
    ST_OPEN    = 2'd2,
    ST_LOCKOUT = 2'd3
`else
    ST_OPEN    = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/lockout_timer.sv
// Lockout down-counter: load arms it for CYCLES cycles, and done pulses on
// the last cycle. Instantiated only when COMBO_LOCKOUT_EN is defined.
module lockout_timer #(
  parameter int CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int TW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Load the full count, then walk down to zero and stay there.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = TW'(CYCLES);
    else if (cnt_q != '0)    cnt_d = cnt_q - TW'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Count value 1 is the final armed cycle, so the owner leaves on this edge.
  assign done = (cnt_q == TW'(1));

endmodule

// File: rtl/combo_check.sv
// Combination lock checker: collects four digits, compares them to CODE one
// cycle later, then opens or pulses fail. Optional lockout after MAX_TRIES
// consecutive wrong codes is enabled with macro COMBO_LOCKOUT_EN.
module combo_check
  import combo_pkg::*;
#(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          MAX_TRIES   = 3,
  parameter int          LOCK_CYCLES = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIGIT_W-1:0]  digitIn,
  input  logic                enter,
  input  logic                clear,
  output logic                unlocked,
  output logic                fail,
  output logic                locked,
  output logic [ENT_W-1:0]    entered,
  output logic [CNT_W-1:0]    digitCount
);

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   entered_q, entered_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               unlocked_q, unlocked_d;
  logic               fail_q, fail_d;

`ifdef COMBO_LOCKOUT_EN
  localparam int FW = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES + 1);

  logic [FW-1:0] fails_q, fails_d;
  logic          locked_q, locked_d;
  logic          tmr_load, tmr_done;

  lockout_timer #(.CYCLES(LOCK_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .done (tmr_done)
  );
`else
  // Lockout parameters have no effect in this build.
  logic unused_cfg;
  assign unused_cfg = (MAX_TRIES != 0) ^ (LOCK_CYCLES != 0);
`endif

  // Next-state and next-output logic; clear outranks enter everywhere.
  always_comb begin
    state_d    = state_q;
    entered_d  = entered_q;
    cnt_d      = cnt_q;
    unlocked_d = unlocked_q;
    fail_d     = 1'b0;
`ifdef COMBO_LOCKOUT_EN
    fails_d    = fails_q;
    locked_d   = locked_q;
    tmr_load   = 1'b0;
`endif
    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          entered_d = '0;
          cnt_d     = '0;
        end else if (enter) begin
          entered_d = {entered_q[ENT_W-DIGIT_W-1:0], digitIn};
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CODE_LEN - 1)) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (entered_q == CODE) begin
          state_d    = ST_OPEN;
          unlocked_d = 1'b1;
`ifdef COMBO_LOCKOUT_EN
          fails_d    = '0;
`endif
        end else begin
          fail_d    = 1'b1;
          entered_d = '0;
          cnt_d     = '0;
          state_d   = ST_ENTRY;
`ifdef COMBO_LOCKOUT_EN
          fails_d   = fails_q + FW'(1);
          if (fails_q + FW'(1) == FW'(MAX_TRIES)) begin
            state_d  = ST_LOCKOUT;
            locked_d = 1'b1;
            tmr_load = 1'b1;
          end
`endif
        end
      end
      ST_OPEN: begin
        if (enter || clear) begin
          unlocked_d = 1'b0;
          entered_d  = '0;
          cnt_d      = '0;
          state_d    = ST_ENTRY;
        end
      end
`ifdef COMBO_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (tmr_done) begin
          state_d  = ST_ENTRY;
          locked_d = 1'b0;
          fails_d  = '0;
        end
      end
`endif
      default: state_d = ST_ENTRY;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      entered_q  <= '0;
      cnt_q      <= '0;
      unlocked_q <= 1'b0;
      fail_q     <= 1'b0;
`ifdef COMBO_LOCKOUT_EN
      fails_q    <= '0;
      locked_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      entered_q  <= entered_d;
      cnt_q      <= cnt_d;
      unlocked_q <= unlocked_d;
      fail_q     <= fail_d;
`ifdef COMBO_LOCKOUT_EN
      fails_q    <= fails_d;
      locked_q   <= locked_d;
`endif
    end
  end

  assign unlocked   = unlocked_q;
  assign fail       = fail_q;
  assign entered    = entered_q;
  assign digitCount = cnt_q;
`ifdef COMBO_LOCKOUT_EN
  assign locked     = locked_q;
`else
  assign locked     = 1'b0;
`endif

endmodule

// File: tb/tb_combo_check.sv
// Directed self-checking bench for combo_check (CODE=1234, MAX_TRIES=3,
// LOCK_CYCLES=10). Lockout scenarios build when COMBO_LOCKOUT_EN is defined.
module tb_combo_check;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digitIn;
  logic        enter;
  logic        clear;
  logic        unlocked;
  logic        fail;
  logic        locked;
  logic [15:0] entered;
  logic [2:0]  digitCount;

  int n_chk  = 0;
  int n_fail = 0;
  int fail_pulses = 0;
  int lock_cycles = 0;

  combo_check #(.CODE(16'h1234), .MAX_TRIES(3), .LOCK_CYCLES(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .digitIn    (digitIn),
    .enter      (enter),
    .clear      (clear),
    .unlocked   (unlocked),
    .fail       (fail),
    .locked     (locked),
    .entered    (entered),
    .digitCount (digitCount)
  );

  always #5 clk = ~clk;

  // Event monitors sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && fail)   fail_pulses <= fail_pulses + 1;
    if (!rst && locked) lock_cycles <= lock_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digitIn = d;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
    digitIn = 4'h0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Enter four digits, then step through the CHECK cycle to the result.
  task automatic enter_code(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".unlocked"}, 32'(unlocked), 32'd0);
    chk({tag, ".fail"},     32'(fail),     32'd0);
    chk({tag, ".locked"},   32'(locked),   32'd0);
    chk({tag, ".entered"},  32'(entered),  32'd0);
    chk({tag, ".count"},    32'(digitCount), 32'd0);
  endtask

  initial begin
    int fp0;
    rst = 1'b1; enter = 1'b0; clear = 1'b0; digitIn = 4'h0;
    tick(); tick();
    rst = 1'b0;
    chk_idle("reset");

    // Correct code, checking latency along the way.
    fp0 = fail_pulses;
    press(4'h1); press(4'h2); press(4'h3);
    chk("t1.entered3", 32'(entered), 32'h123);
    chk("t1.count3",   32'(digitCount), 32'd3);
    press(4'h4);
    chk("t1.count4",   32'(digitCount), 32'd4);
    chk("t1.entered4", 32'(entered), 32'h1234);
    chk("t1.check_unl", 32'(unlocked), 32'd0);
    tick();
    chk("t1.unlocked", 32'(unlocked), 32'd1);
    chk("t1.entered",  32'(entered), 32'h1234);
    chk("t1.nofail",   32'(fail_pulses - fp0), 32'd0);
    pulse_clear();
    chk_idle("t1.relock");

    // Wrong code: one-cycle fail pulse.
    press(4'h1); press(4'h2); press(4'h3); press(4'h5);
    chk("t2.check_fail", 32'(fail), 32'd0);
    tick();
    chk("t2.fail",     32'(fail), 32'd1);
    chk("t2.entered",  32'(entered), 32'd0);
    chk("t2.count",    32'(digitCount), 32'd0);
    chk("t2.unlocked", 32'(unlocked), 32'd0);
    tick();
    chk("t2.fail_end", 32'(fail), 32'd0);

    // Enter and clear together: clear wins, digit discarded.
    press(4'h1); press(4'h2);
    digitIn = 4'h3; enter = 1'b1; clear = 1'b1;
    tick();
    enter = 1'b0; clear = 1'b0;
    chk("t3.entered", 32'(entered), 32'd0);
    chk("t3.count",   32'(digitCount), 32'd0);
    enter_code(16'h1234);
    chk("t3.unlocked", 32'(unlocked), 32'd1);

    // Enter in OPEN relocks and the digit is dropped.
    press(4'h9);
    chk_idle("t4.open_enter");

    // Digit F is legal.
    press(4'hF);
    chk("t5.digitF", 32'(entered), 32'hF);
    pulse_clear();
    chk("t5.clear", 32'(entered), 32'd0);

    // Enter during CHECK is ignored.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(4'h7);
    chk("t6.check_unl", 32'(unlocked), 32'd1);
    chk("t6.check_ent", 32'(entered), 32'h1234);

    // Reset while OPEN.
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle("t7.rst_open");

`ifdef COMBO_LOCKOUT_EN
    // Three wrong codes: lockout for exactly 10 cycles.
    enter_code(16'h1111);
    enter_code(16'h2222);
    chk("t8.notlocked", 32'(locked), 32'd0);
    lock_cycles = 0;
    enter_code(16'h3333);
    chk("t8.fail3",  32'(fail), 32'd1);
    chk("t8.locked", 32'(locked), 32'd1);
    press(4'h1); press(4'h2);
    chk("t8.ign_ent", 32'(entered), 32'd0);
    chk("t8.ign_cnt", 32'(digitCount), 32'd0);
    chk("t8.still",   32'(locked), 32'd1);
    begin
      int guard = 0;
      while (locked && guard < 40) begin tick(); guard++; end
      chk("t8.expired", 32'(locked), 32'd0);
    end
    tick();
    chk("t8.lock_len", 32'(lock_cycles), 32'd10);
    enter_code(16'h1234);
    chk("t8.unlock_after", 32'(unlocked), 32'd1);
    pulse_clear();

    // Reset in the middle of a lockout.
    enter_code(16'h1111);
    enter_code(16'h1111);
    enter_code(16'h1111);
    tick(); tick();
    chk("t9.locked", 32'(locked), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk_idle("t9.rst_lock");
    press(4'h6);
    chk("t9.entry_ok", 32'(entered), 32'h6);
    pulse_clear();
`else
    // Five wrong codes: five fail pulses, never locked.
    lock_cycles = 0;
    fp0 = fail_pulses;
    for (int i = 0; i < 5; i++) begin
      enter_code(16'h4321);
      chk("t8.fail", 32'(fail), 32'd1);
    end
    tick();
    chk("t8.pulses", 32'(fail_pulses - fp0), 32'd5);
    chk("t8.never_locked", 32'(lock_cycles), 32'd0);
    enter_code(16'h1234);
    chk("t8.unlock_after", 32'(unlocked), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
